tag_regfile: RTL and testbench

Parametrised register file with per-register reservation tags for the Tomasulo issue/CDB path. It is the successor of the single-CDB FP register file. It adds width, depth and tag generalisation, NCDB broadcast ports, same-cycle CDB bypass to the operand outputs, a branch-recovery flush and an optional hardwired zero register. It sits between the issue stage (rename and operand read) and the common data buses (writeback).

---
 rtl/tomasulo_pkg.sv | 26 ++
 rtl/tag_regfile_cdb_match.sv | 28 ++
 rtl/tag_regfile.sv | 114 +++++++++++
 tb/tb_tag_regfile.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: reservation-station tags, branch opcodes and the tag type.
package tomasulo_pkg;
  localparam int RS_TAG_W = 4;
  typedef logic [RS_TAG_W-1:0] tag_t;

  // Tag 0 marks a register whose value is final.
  localparam tag_t NOTAG  = 4'd0;
  localparam tag_t add_1  = 4'd1;
  localparam tag_t add_2  = 4'd2;
  localparam tag_t add_3  = 4'd3;
  localparam tag_t mult_1 = 4'd4;
  localparam tag_t mult_2 = 4'd5;
  localparam tag_t ld_1   = 4'd6;
  localparam tag_t ld_2   = 4'd7;
  localparam tag_t ld_3   = 4'd8;
  localparam tag_t st_1   = 4'd9;
  localparam tag_t st_2   = 4'd10;

  localparam logic [5:0] op_beq = 6'h04;
  localparam logic [5:0] op_jmp = 6'h02;

  // Store stations never produce a register result, so the issue stage raises nodest for them.
  function automatic logic is_store_tag(input tag_t t);
    return (t == st_1) || (t == st_2);
  endfunction
endpackage

// File: rtl/tag_regfile_cdb_match.sv
// Finds the CDB port broadcasting a given tag; the lowest port index wins on duplicates.
module cdb_match import tomasulo_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int NCDB   = 1,
  parameter int PORT_W = (NCDB > 1) ? $clog2(NCDB) : 1
) (
  input  logic [TAG_W-1:0]       tag,
  input  logic [NCDB*TAG_W-1:0]  cdb_id,
  input  logic [NCDB*DATA_W-1:0] cdb_data,
  output logic                   hit,
  output logic [DATA_W-1:0]      data,
  output logic [PORT_W-1:0]      port
);
  // Scanning downwards lets the lowest matching port overwrite any higher one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    port = '0;
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (tag != TAG_W'(NOTAG) && cdb_id[k*TAG_W +: TAG_W] == tag) begin
        hit  = 1'b1;
        data = cdb_data[k*DATA_W +: DATA_W];
        port = PORT_W'(k);
      end
    end
  end
endmodule

// File: rtl/tag_regfile.sv
// Register file with reservation tags: rename on issue, multi-port CDB writeback,
// same-cycle CDB bypass on operand reads, flush and optional hardwired zero register.
module tag_regfile import tomasulo_pkg::*; #(
  parameter int DATA_W   = 64,
  parameter int NREGS    = 32,
  parameter int TAG_W    = 4,
  parameter int NCDB     = 1,
  parameter int ZERO_REG = 0,
  localparam int IDX_W   = $clog2(NREGS),
  localparam int PORT_W  = (NCDB > 1) ? $clog2(NCDB) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic                    stall,
  input  logic [TAG_W-1:0]        issue_tag,
  input  logic                    nodest,
  input  logic [IDX_W-1:0]        reg_src_1,
  input  logic [IDX_W-1:0]        reg_src_2,
  input  logic [IDX_W-1:0]        reg_dest,
  input  logic                    ign_tag_1,
  input  logic                    ign_tag_2,
  input  logic                    flush,
  input  logic [NCDB*TAG_W-1:0]   cdb_id,
  input  logic [NCDB*DATA_W-1:0]  cdb_data,
  output logic [DATA_W-1:0]       op_1,
  output logic [DATA_W-1:0]       op_2,
  output logic [TAG_W-1:0]        tag_1,
  output logic [TAG_W-1:0]        tag_2,
  output logic                    all_clear,
  output logic [NREGS*DATA_W-1:0] tb_regs
);
  logic [DATA_W-1:0] regs [NREGS];
  logic [TAG_W-1:0]  tags [NREGS];
  logic [NREGS-1:0]  wb_hit;
  logic [DATA_W-1:0] wb_data [NREGS];
  logic              rename_en;
  logic              zero_dest;

  assign zero_dest = (ZERO_REG != 0) && (reg_dest == '0);
  assign rename_en = issue_valid & ~stall & ~nodest & (issue_tag != TAG_W'(NOTAG))
                   & ~flush & ~zero_dest;

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      wb_hit[i]  = 1'b0;
      wb_data[i] = '0;
      for (int k = NCDB - 1; k >= 0; k--) begin
        if (tags[i] != TAG_W'(NOTAG) && cdb_id[k*TAG_W +: TAG_W] == tags[i]) begin
          wb_hit[i]  = 1'b1;
          wb_data[i] = cdb_data[k*DATA_W +: DATA_W];
        end
      end
      if (ZERO_REG != 0 && i == 0) wb_hit[i] = 1'b0;
    end
  end

  // A rename in the same cycle as a matching broadcast keeps the new tag (WAW order).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_hit[i]) regs[i] <= wb_data[i];
        if (flush) tags[i] <= '0;
        else if (rename_en && reg_dest == IDX_W'(i)) tags[i] <= issue_tag;
        else if (wb_hit[i]) tags[i] <= '0;
      end
    end
  end

  logic              m1_hit, m2_hit;
  logic [DATA_W-1:0] m1_data, m2_data;
  logic [PORT_W-1:0] m1_port, m2_port;
  logic              unused_ports;

  cdb_match #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NCDB(NCDB), .PORT_W(PORT_W)) u_match_1 (
    .tag(tags[reg_src_1]), .cdb_id(cdb_id), .cdb_data(cdb_data),
    .hit(m1_hit), .data(m1_data), .port(m1_port)
  );
  cdb_match #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NCDB(NCDB), .PORT_W(PORT_W)) u_match_2 (
    .tag(tags[reg_src_2]), .cdb_id(cdb_id), .cdb_data(cdb_data),
    .hit(m2_hit), .data(m2_data), .port(m2_port)
  );
  assign unused_ports = ^{m1_port, m2_port};

  // Reads see pre-edge state; ignore is applied after the bypass.
  always_comb begin
    op_1  = '0;
    tag_1 = '0;
    op_2  = '0;
    tag_2 = '0;
    if (issue_valid && !(ZERO_REG != 0 && reg_src_1 == '0)) begin
      op_1  = m1_hit ? m1_data : regs[reg_src_1];
      tag_1 = (m1_hit || ign_tag_1) ? '0 : tags[reg_src_1];
    end
    if (issue_valid && !(ZERO_REG != 0 && reg_src_2 == '0)) begin
      op_2  = m2_hit ? m2_data : regs[reg_src_2];
      tag_2 = (m2_hit || ign_tag_2) ? '0 : tags[reg_src_2];
    end
  end

  always_comb begin
    all_clear = 1'b1;
    tb_regs   = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (tags[i] != TAG_W'(NOTAG)) all_clear = 1'b0;
      tb_regs[i*DATA_W +: DATA_W] = regs[i];
    end
  end
endmodule

// File: tb/tb_tag_regfile.sv
// Bench for tag_regfile: directed vector table, hand sequences and random traffic
// against a reference model, on a plain instance and a zero-register instance.
module tb_tag_regfile;
  localparam int DATA_W = 64;
  localparam int NREGS  = 32;
  localparam int TAG_W  = 4;
  localparam int NCDB   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                    issue_valid, stall, nodest, flush, ign_tag_1, ign_tag_2;
  logic [TAG_W-1:0]        issue_tag;
  logic [4:0]              reg_src_1, reg_src_2, reg_dest;
  logic [NCDB*TAG_W-1:0]   cdb_id;
  logic [NCDB*DATA_W-1:0]  cdb_data;
  logic [DATA_W-1:0]       op_1_a, op_2_a, op_1_z, op_2_z;
  logic [TAG_W-1:0]        tag_1_a, tag_2_a, tag_1_z, tag_2_z;
  logic                    all_clear_a, all_clear_z;
  logic [NREGS*DATA_W-1:0] tb_regs_a, tb_regs_z;

  tag_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .TAG_W(TAG_W), .NCDB(NCDB), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .stall(stall), .issue_tag(issue_tag),
    .nodest(nodest), .reg_src_1(reg_src_1), .reg_src_2(reg_src_2), .reg_dest(reg_dest),
    .ign_tag_1(ign_tag_1), .ign_tag_2(ign_tag_2), .flush(flush), .cdb_id(cdb_id),
    .cdb_data(cdb_data), .op_1(op_1_a), .op_2(op_2_a), .tag_1(tag_1_a), .tag_2(tag_2_a),
    .all_clear(all_clear_a), .tb_regs(tb_regs_a)
  );

  tag_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .TAG_W(TAG_W), .NCDB(NCDB), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .stall(stall), .issue_tag(issue_tag),
    .nodest(nodest), .reg_src_1(reg_src_1), .reg_src_2(reg_src_2), .reg_dest(reg_dest),
    .ign_tag_1(ign_tag_1), .ign_tag_2(ign_tag_2), .flush(flush), .cdb_id(cdb_id),
    .cdb_data(cdb_data), .op_1(op_1_z), .op_2(op_2_z), .tag_1(tag_1_z), .tag_2(tag_2_z),
    .all_clear(all_clear_z), .tb_regs(tb_regs_z)
  );

  // Reference model: index 0 = plain instance, index 1 = zero-register instance.
  logic [DATA_W-1:0] m_regs [2][NREGS];
  logic [TAG_W-1:0]  m_tags [2][NREGS];
  logic [DATA_W-1:0] n_regs [2][NREGS];
  logic [TAG_W-1:0]  n_tags [2][NREGS];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic iv, st, nd, fl, i1, i2;
    logic [3:0] it;
    logic [4:0] s1, s2, d;
    logic [3:0] id0, id1;
    logic [63:0] d0, d1;
    logic [63:0] eo1, eo2;
    logic [3:0] et1, et2;
    logic eac;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  function automatic vec_t mk(input logic iv, st, nd, fl, i1, i2, input logic [3:0] it,
                              input logic [4:0] s1, s2, d, input logic [3:0] id0,
                              input logic [63:0] d0, input logic [3:0] id1, input logic [63:0] d1,
                              input logic [63:0] eo1, input logic [3:0] et1,
                              input logic [63:0] eo2, input logic [3:0] et2, input logic eac);
    vec_t v;
    v.iv = iv; v.st = st; v.nd = nd; v.fl = fl; v.i1 = i1; v.i2 = i2; v.it = it;
    v.s1 = s1; v.s2 = s2; v.d = d; v.id0 = id0; v.d0 = d0; v.id1 = id1; v.d1 = d1;
    v.eo1 = eo1; v.et1 = et1; v.eo2 = eo2; v.et2 = et2; v.eac = eac;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < NREGS; i++) begin
        m_regs[z][i] = '0;
        m_tags[z][i] = '0;
      end
  endfunction

  function automatic void model_read(input int z, input logic [4:0] src, input logic ign,
                                     output logic [63:0] op, output logic [3:0] tag);
    op = '0;
    tag = '0;
    if (!issue_valid || (z == 1 && src == 0)) return;
    op = m_regs[z][src];
    tag = m_tags[z][src];
    if (tag != 0)
      for (int k = 0; k < NCDB; k++)
        if (cdb_id[k*TAG_W +: TAG_W] == tag) begin
          op = cdb_data[k*DATA_W +: DATA_W];
          tag = '0;
          break;
        end
    if (ign) tag = '0;
  endfunction

  function automatic logic model_clear(input int z);
    for (int i = 0; i < NREGS; i++)
      if (m_tags[z][i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Next state from the current inputs, applying the writeback/rename/flush rules.
  function automatic void model_next();
    bit ren;
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < NREGS; i++) begin
        int hit_k;
        hit_k = -1;
        if (m_tags[z][i] != 0 && !(z == 1 && i == 0))
          for (int k = 0; k < NCDB; k++)
            if (hit_k < 0 && cdb_id[k*TAG_W +: TAG_W] == m_tags[z][i]) hit_k = k;
        ren = issue_valid && !stall && !nodest && issue_tag != 0 && !flush &&
              int'(reg_dest) == i && !(z == 1 && i == 0);
        n_regs[z][i] = (hit_k >= 0) ? cdb_data[hit_k*DATA_W +: DATA_W] : m_regs[z][i];
        if (flush) n_tags[z][i] = '0;
        else if (ren) n_tags[z][i] = issue_tag;
        else if (hit_k >= 0) n_tags[z][i] = '0;
        else n_tags[z][i] = m_tags[z][i];
      end
  endfunction

  task automatic check_model(input string tagname);
    logic [63:0] eo1, eo2;
    logic [3:0]  et1, et2;
    for (int z = 0; z < 2; z++) begin
      model_read(z, reg_src_1, ign_tag_1, eo1, et1);
      model_read(z, reg_src_2, ign_tag_2, eo2, et2);
      check($sformatf("%s m%0d op_1", tagname, z), z == 0 ? op_1_a : op_1_z, eo1);
      check($sformatf("%s m%0d tag_1", tagname, z), z == 0 ? 64'(tag_1_a) : 64'(tag_1_z), 64'(et1));
      check($sformatf("%s m%0d op_2", tagname, z), z == 0 ? op_2_a : op_2_z, eo2);
      check($sformatf("%s m%0d tag_2", tagname, z), z == 0 ? 64'(tag_2_a) : 64'(tag_2_z), 64'(et2));
      check($sformatf("%s m%0d all_clear", tagname, z),
            z == 0 ? 64'(all_clear_a) : 64'(all_clear_z), 64'(model_clear(z)));
    end
  endtask

  task automatic check_regs(input string tagname);
    for (int i = 0; i < NREGS; i++) begin
      check($sformatf("%s regs_a[%0d]", tagname, i), tb_regs_a[i*DATA_W +: DATA_W], m_regs[0][i]);
      check($sformatf("%s regs_z[%0d]", tagname, i), tb_regs_z[i*DATA_W +: DATA_W], m_regs[1][i]);
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    m_regs = n_regs;
    m_tags = n_tags;
    #1;
  endtask

  task automatic set_idle();
    issue_valid = 0; stall = 0; nodest = 0; flush = 0; ign_tag_1 = 0; ign_tag_2 = 0;
    issue_tag = 0; reg_src_1 = 0; reg_src_2 = 0; reg_dest = 0; cdb_id = '0; cdb_data = '0;
  endtask

  task automatic apply(input vec_t v);
    issue_valid = v.iv; stall = v.st; nodest = v.nd; flush = v.fl;
    ign_tag_1 = v.i1; ign_tag_2 = v.i2; issue_tag = v.it;
    reg_src_1 = v.s1; reg_src_2 = v.s2; reg_dest = v.d;
    cdb_id = {v.id1, v.id0};
    cdb_data = {v.d1, v.d0};
  endtask

  initial begin
    //          iv st nd fl i1 i2 it  s1  s2  d   id0 d0       id1 d1     eo1      et1 eo2      et2 eac
    vt[0]  = mk(1, 0, 0, 0, 0, 0, 1,  3,  4,  5,  0,  0,       0,  0,     0,       0,  0,       0,  1);
    vt[1]  = mk(1, 0, 0, 0, 0, 0, 0,  5,  3,  0,  0,  0,       0,  0,     0,       1,  0,       0,  0);
    vt[2]  = mk(1, 0, 0, 0, 0, 0, 0,  5,  5,  0,  1,  'hDEAD,  0,  0,     'hDEAD,  0,  'hDEAD,  0,  0);
    vt[3]  = mk(1, 0, 0, 0, 0, 0, 4,  5,  0,  2,  0,  0,       0,  0,     'hDEAD,  0,  0,       0,  1);
    vt[4]  = mk(1, 0, 0, 0, 0, 0, 4,  2,  7,  7,  0,  0,       0,  0,     0,       4,  0,       0,  0);
    vt[5]  = mk(1, 0, 0, 0, 0, 0, 0,  2,  7,  0,  0,  0,       4,  'h11,  'h11,    0,  'h11,    0,  0);
    vt[6]  = mk(1, 0, 0, 0, 0, 0, 2,  2,  7,  3,  0,  0,       0,  0,     'h11,    0,  'h11,    0,  1);
    vt[7]  = mk(1, 0, 0, 0, 0, 0, 5,  3,  7,  3,  2,  'h55,    0,  0,     'h55,    0,  'h11,    0,  0);
    vt[8]  = mk(1, 0, 0, 0, 0, 0, 1,  3,  5,  8,  0,  0,       0,  0,     'h55,    5,  'hDEAD,  0,  0);
    vt[9]  = mk(1, 0, 0, 0, 0, 0, 6,  8,  9,  9,  0,  0,       0,  0,     0,       1,  0,       0,  0);
    vt[10] = mk(1, 0, 0, 0, 0, 0, 0,  8,  9,  0,  1,  'hA,     6,  'hB,   'hA,     0,  'hB,     0,  0);
    vt[11] = mk(1, 0, 0, 0, 0, 0, 3,  8,  9,  10, 0,  0,       0,  0,     'hA,     0,  'hB,     0,  0);
    vt[12] = mk(1, 0, 0, 0, 0, 0, 3,  10, 11, 11, 0,  0,       0,  0,     0,       3,  0,       0,  0);
    vt[13] = mk(1, 0, 0, 0, 0, 0, 0,  10, 11, 0,  3,  'hC0,    3,  'hC1,  'hC0,    0,  'hC0,    0,  0);
    vt[14] = mk(1, 0, 0, 0, 0, 0, 4,  10, 11, 1,  0,  0,       0,  0,     'hC0,    0,  'hC0,    0,  0);
    vt[15] = mk(1, 0, 0, 1, 0, 0, 6,  1,  2,  2,  5,  'h99,    0,  0,     0,       4,  'h11,    0,  0);
    vt[16] = mk(1, 0, 0, 0, 0, 0, 7,  1,  2,  6,  0,  0,       0,  0,     0,       0,  'h11,    0,  1);
    vt[17] = mk(1, 0, 0, 0, 0, 1, 0,  3,  6,  0,  0,  0,       0,  0,     'h99,    0,  0,       0,  0);
    vt[18] = mk(1, 1, 0, 0, 0, 1, 2,  6,  6,  12, 0,  0,       0,  0,     0,       7,  0,       0,  0);
    vt[19] = mk(1, 0, 0, 0, 0, 0, 0,  12, 6,  0,  0,  0,       0,  0,     0,       0,  0,       7,  0);
    vt[20] = mk(0, 0, 0, 0, 0, 0, 0,  6,  6,  0,  0,  0,       0,  0,     0,       0,  0,       0,  0);
    vt[21] = mk(1, 0, 1, 0, 0, 0, 9,  6,  0,  13, 7,  'h70,    0,  0,     'h70,    0,  0,       0,  0);
    vt[22] = mk(1, 0, 0, 0, 0, 0, 0,  13, 6,  0,  0,  0,       0,  0,     0,       0,  'h70,    0,  1);

    set_idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_regs("reset");

    for (int n = 0; n < NV; n++) begin
      apply(vt[n]);
      #1;
      check($sformatf("row%0d op_1", n), op_1_a, vt[n].eo1);
      check($sformatf("row%0d tag_1", n), 64'(tag_1_a), 64'(vt[n].et1));
      check($sformatf("row%0d op_2", n), op_2_a, vt[n].eo2);
      check($sformatf("row%0d tag_2", n), 64'(tag_2_a), 64'(vt[n].et2));
      check($sformatf("row%0d all_clear", n), 64'(all_clear_a), 64'(vt[n].eac));
      check_model($sformatf("row%0d", n));
      tick();
    end
    check("after table F5", tb_regs_a[5*DATA_W +: DATA_W], 64'hDEAD);
    check("after table F3", tb_regs_a[3*DATA_W +: DATA_W], 64'h99);
    check("after table F11", tb_regs_a[11*DATA_W +: DATA_W], 64'hC0);
    check_regs("table");

    // Zero register: rename and broadcast on R0 only affect the plain instance.
    set_idle();
    issue_valid = 1; issue_tag = 3; reg_dest = 0;
    #1;
    check_model("zr0");
    tick();
    issue_tag = 0;
    #1;
    check("zr tag_1 plain", 64'(tag_1_a), 64'd3);
    check("zr tag_1 zero", 64'(tag_1_z), 64'd0);
    cdb_id = {4'd0, 4'd3};
    cdb_data = {64'd0, 64'h42};
    #1;
    check("zr op_1 plain bypass", op_1_a, 64'h42);
    check("zr op_1 zero", op_1_z, 64'd0);
    check_model("zr1");
    tick();
    set_idle();
    #1;
    check("zr reg0 plain", tb_regs_a[DATA_W-1:0], 64'h42);
    check("zr reg0 zero", tb_regs_z[DATA_W-1:0], 64'd0);
    check("zr all_clear plain", 64'(all_clear_a), 64'd1);

    // Asynchronous reset between clock edges.
    issue_valid = 1; issue_tag = 2; reg_dest = 5; reg_src_1 = 5;
    #1;
    check_model("ar0");
    tick();
    issue_tag = 0;
    #1;
    check("pre-rst tag_1", 64'(tag_1_a), 64'd2);
    check("pre-rst all_clear", 64'(all_clear_a), 64'd0);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst tag_1", 64'(tag_1_a), 64'd0);
    check("rst all_clear", 64'(all_clear_a), 64'd1);
    check("rst F5", tb_regs_a[5*DATA_W +: DATA_W], 64'd0);
    set_idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_regs("post-rst");

    for (int c = 0; c < 400; c++) begin
      issue_valid = ($urandom_range(0, 9) < 8);
      stall = ($urandom_range(0, 9) == 0);
      nodest = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 29) == 0);
      ign_tag_1 = ($urandom_range(0, 7) == 0);
      ign_tag_2 = ($urandom_range(0, 7) == 0);
      issue_tag = 4'($urandom_range(0, 5));
      reg_src_1 = 5'($urandom_range(0, 7));
      reg_src_2 = 5'($urandom_range(0, 7));
      reg_dest = 5'($urandom_range(0, 7));
      cdb_id = {($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 5)),
                ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 5))};
      cdb_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check_model($sformatf("rnd%0d", c));
      if (c % 50 == 49) check_regs($sformatf("rnd%0d", c));
      tick();
    end
    set_idle();
    #1;
    check_regs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
